// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_t   : controller states (idle, running, paused)
//   SEG7_LUT  : abcdefg segment codes (a = bit 6, active-high) for digits 0-9
//   DIGIT_SEL : active-low digit enables for scan slots 0 (ones) .. 3 (thousands)
//   bcd_inc   : single BCD digit increment returning {carry, next digit}
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_t;

  // Element 0 is the rightmost entry of each concatenation.
  localparam logic [9:0][6:0] SEG7_LUT = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam logic [3:0][3:0] DIGIT_SEL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
    logic [4:0] res;
    if (digit >= 4'd9) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   btn_i   : raw button level, asynchronous to clk_i
//   pulse_o : single-cycle pulse per press, valid 2 cycles after the first
//             clock edge that samples btn_i high
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= btn_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign pulse_o = r_sync & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/clear FSM, 1-second prescaler, 4-digit BCD
// counter and time-multiplexed seven-segment scan.
//   clk_i         : system clock
//   rst_i         : asynchronous active-high reset
//   start_stop_i  : raw start/stop button level
//   clear_i       : raw clear button level
//   running_o     : high while in RUN (registered)
//   bcd_o         : count, [15:12] thousands .. [3:0] ones
//   wrap_o        : one-cycle pulse with bcd_o on the 9999 -> 0000 rollover
//   led_segment_o : segments abcdefg, active-low
//   digit_o       : digit enables, active-low
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_stop_i,
  input  logic        clear_i,
  output logic        running_o,
  output logic [15:0] bcd_o,
  output logic        wrap_o,
  output logic [6:0]  led_segment_o,
  output logic [3:0]  digit_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  // Keep at least one bit so SCAN_DIV = 1 still elaborates.
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic w_ss_evt;
  logic w_clr_evt;

  btn_sync_edge u_ss_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (start_stop_i),
    .pulse_o (w_ss_evt)
  );

  btn_sync_edge u_clr_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (clear_i),
    .pulse_o (w_clr_evt)
  );

  state_t        r_state;
  state_t        w_state_d;
  logic          w_clr_cnt;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_d;
  logic          w_tick;
  logic [15:0]   r_bcd;
  logic [15:0]   w_bcd_inc;
  logic [4:0]    w_inc [4];
  logic          w_all_carry;
  logic          r_wrap;

  // Clear only acts from PAUSE; in RUN start/stop takes precedence and the
  // clear is dropped, in PAUSE the clear takes precedence.
  always_comb begin
    w_state_d = r_state;
    w_clr_cnt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ss_evt) w_state_d = StRun;
      end
      StRun: begin
        if (w_ss_evt) w_state_d = StPause;
      end
      StPause: begin
        if (w_clr_evt) begin
          w_state_d = StIdle;
          w_clr_cnt = 1'b1;
        end else if (w_ss_evt) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_tick = (r_state == StRun) && (r_presc == PW'(TICK_DIV - 1));

  // Prescaler holds in PAUSE so a resumed run keeps its partial second; it is
  // forced to zero in IDLE so every fresh start gets a full first second.
  always_comb begin
    w_presc_d = r_presc;
    if (r_state == StRun) begin
      w_presc_d = w_tick ? '0 : r_presc + 1'b1;
    end else if ((r_state == StIdle) || w_clr_cnt) begin
      w_presc_d = '0;
    end
  end

  // Ripple BCD increment: a digit advances only when every lower digit wraps.
  always_comb begin
    w_bcd_inc   = r_bcd;
    w_all_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_inc[i] = bcd_inc(r_bcd[4*i +: 4]);
      if (w_all_carry) w_bcd_inc[4*i +: 4] = w_inc[i][3:0];
      w_all_carry = w_all_carry & w_inc[i][4];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_bcd     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_running <= (w_state_d == StRun);
      r_presc   <= w_presc_d;
      r_wrap    <= w_tick & w_all_carry;
      if (w_clr_cnt) begin
        r_bcd <= '0;
      end else if (w_tick) begin
        r_bcd <= w_bcd_inc;
      end
    end
  end

  // Scan: sub-slot counter plus slot index together form a counter modulo
  // 4*SCAN_DIV whose quotient by SCAN_DIV is the slot.
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    w_cur_digit;
  logic [3:0]    r_digit;
  logic [6:0]    r_seg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_scan_cnt <= '0;
      r_slot     <= 2'd0;
    end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_slot     <= r_slot + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_cur_digit = r_bcd[3:0];
    unique case (r_slot)
      2'd0: w_cur_digit = r_bcd[3:0];
      2'd1: w_cur_digit = r_bcd[7:4];
      2'd2: w_cur_digit = r_bcd[11:8];
      2'd3: w_cur_digit = r_bcd[15:12];
      default: w_cur_digit = r_bcd[3:0];
    endcase
  end

  // Enables and segments share one register stage so they always switch in
  // the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_digit <= 4'b1111;
      r_seg   <= 7'h7F;
    end else begin
      r_digit <= DIGIT_SEL[r_slot];
      r_seg   <= ~SEG7_LUT[w_cur_digit];
    end
  end

  assign running_o     = r_running;
  assign bcd_o         = r_bcd;
  assign wrap_o        = r_wrap;
  assign led_segment_o = r_seg;
  assign digit_o       = r_digit;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: TICK_DIV=4, SCAN_DIV=2
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic        running;
  logic [15:0] bcd;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  digit;

  // Rollover instance: TICK_DIV=2, SCAN_DIV=2
  logic        ss_w = 1'b0;
  logic        clr_w = 1'b0;
  logic        running_w;
  logic [15:0] bcd_w;
  logic        wrap_w;
  logic [6:0]  seg_w;
  logic [3:0]  digit_w;

  stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_stop_i  (ss),
    .clear_i       (clr),
    .running_o     (running),
    .bcd_o         (bcd),
    .wrap_o        (wrap),
    .led_segment_o (seg),
    .digit_o       (digit)
  );

  stopwatch_ctrl #(.TICK_DIV(2), .SCAN_DIV(2)) u_dut_w (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_stop_i  (ss_w),
    .clear_i       (clr_w),
    .running_o     (running_w),
    .bcd_o         (bcd_w),
    .wrap_o        (wrap_w),
    .led_segment_o (seg_w),
    .digit_o       (digit_w)
  );

  int checks = 0;
  int errors = 0;
  int wraps_seen = 0;
  int w_model = 0;
  logic [15:0] prev_bcd = 16'h0;
  logic [15:0] w_prev = 16'h0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle press; returns one edge later, the FSM acts two edges after that.
  task automatic press(input logic s, input logic c);
    ss  = s;
    clr = c;
    cyc(1);
    ss  = 1'b0;
    clr = 1'b0;
  endtask

  // Scoreboard for the main instance: every bcd change must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_bcd = bcd;
    end else if (bcd !== prev_bcd) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(bcd), 32'(prev_bcd));
      else chk("sb_bcd", 32'(bcd), 32'(exp_q.pop_front()));
      prev_bcd = bcd;
    end
  end

  // Reference count for the rollover instance.
  always @(negedge clk) begin
    if (rst) begin
      w_model = 0;
      w_prev  = bcd_w;
    end else begin
      if (bcd_w !== w_prev) begin
        w_model = (w_model + 1) % 10000;
        chk("w_inc", 32'(bcd_w), 32'(to_bcd(w_model)));
        chk("w_wrap_flag", 32'(wrap_w), 32'(w_model == 0));
      end else if (wrap_w) begin
        chk("w_wrap_stray", 32'(wrap_w), 32'd0);
      end
      if (wrap_w) wraps_seen++;
      w_prev = bcd_w;
    end
  end

  logic [3:0] dsel [4];
  logic [6:0] segx [4];
  logic       found;
  logic [3:0] prev_digit;

  initial begin
    dsel = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    segx = '{7'h4C, 7'h06, 7'h12, 7'h4F};

    // Reset
    cyc(3);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_digit", 32'(digit), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    chk("rel_digit", 32'(digit), 32'hF);
    chk("rel_seg", 32'(seg), 32'h7F);
    cyc(1);
    chk("scan0_digit", 32'(digit), 32'h7);
    chk("scan0_seg", 32'(seg), 32'h01);

    // Start and count
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    press(1'b1, 1'b0);
    cyc(1);
    chk("start_lat", 32'(running), 32'd0);
    cyc(1);
    chk("start_run", 32'(running), 32'd1);
    cyc(3);
    chk("tick_early", 32'(bcd), 32'h0);
    cyc(1);
    chk("tick1", 32'(bcd), 32'h1);
    cyc(4);
    chk("tick2", 32'(bcd), 32'h2);
    cyc(4);
    chk("tick3", 32'(bcd), 32'h3);

    // Pause with prescaler at 2, then resume
    exp_q.push_back(16'h0004);
    cyc(3);
    press(1'b1, 1'b0);
    chk("tick4", 32'(bcd), 32'h4);
    cyc(2);
    chk("pause_run", 32'(running), 32'd0);
    cyc(50);
    chk("pause_frozen", 32'(bcd), 32'h4);
    exp_q.push_back(16'h0005);
    press(1'b1, 1'b0);
    cyc(2);
    chk("resume_run", 32'(running), 32'd1);
    cyc(1);
    chk("resume_hold", 32'(bcd), 32'h4);
    cyc(1);
    chk("resume_tick", 32'(bcd), 32'h5);

    // Clear in RUN is ignored
    exp_q.push_back(16'h0006);
    press(1'b0, 1'b1);
    cyc(2);
    chk("clr_run_state", 32'(running), 32'd1);
    chk("clr_run_bcd", 32'(bcd), 32'h5);
    cyc(1);
    chk("clr_run_tick", 32'(bcd), 32'h6);

    // ss+clear in RUN -> PAUSE with count kept
    press(1'b1, 1'b1);
    cyc(2);
    chk("both_run_state", 32'(running), 32'd0);
    chk("both_run_bcd", 32'(bcd), 32'h6);
    cyc(8);
    chk("both_run_hold", 32'(bcd), 32'h6);

    // Clear in PAUSE -> IDLE, count zeroed
    exp_q.push_back(16'h0000);
    press(1'b0, 1'b1);
    cyc(2);
    chk("clr_pause_run", 32'(running), 32'd0);
    chk("clr_pause_bcd", 32'(bcd), 32'h0);

    // ss+clear in PAUSE -> IDLE
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    press(1'b1, 1'b0);
    cyc(2);
    chk("restart_run", 32'(running), 32'd1);
    cyc(8);
    chk("restart_bcd", 32'(bcd), 32'h2);
    press(1'b1, 1'b0);
    cyc(2);
    chk("repause_run", 32'(running), 32'd0);
    exp_q.push_back(16'h0000);
    press(1'b1, 1'b1);
    cyc(2);
    chk("both_pause_bcd", 32'(bcd), 32'h0);
    cyc(4);
    chk("both_pause_idle", 32'(running), 32'd0);

    // Fresh start gets a full first second
    exp_q.push_back(16'h0001);
    press(1'b1, 1'b0);
    cyc(2);
    chk("start3_run", 32'(running), 32'd1);
    cyc(3);
    chk("start3_early", 32'(bcd), 32'h0);
    cyc(1);
    chk("start3_tick", 32'(bcd), 32'h1);

    // Reset mid-RUN
    cyc(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_running", 32'(running), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'h0);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    chk("mid_rst_digit", 32'(digit), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    cyc(2);
    rst = 1'b0;

    // Count to 1234 and pause for the scan check
    for (int i = 1; i <= 1234; i++) exp_q.push_back(to_bcd(i));
    press(1'b1, 1'b0);
    cyc(2);
    cyc(4934);
    press(1'b1, 1'b0);
    cyc(2);
    chk("scan_paused", 32'(running), 32'd0);
    chk("scan_bcd", 32'(bcd), 32'h1234);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    found = 1'b0;
    prev_digit = digit;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (digit === 4'b0111 && prev_digit !== 4'b0111) found = 1'b1;
      else prev_digit = digit;
    end
    chk("scan_sync", 32'(found), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("scan_digit", 32'(digit), 32'(dsel[(k / 2) % 4]));
      chk("scan_seg", 32'(seg), 32'(segx[(k / 2) % 4]));
      @(negedge clk);
    end

    // Full rollover on the fast instance
    @(posedge clk);
    #1;
    ss_w = 1'b1;
    cyc(1);
    ss_w = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20100 && !found; i++) begin
      @(negedge clk);
      if (bcd_w === 16'h9999) found = 1'b1;
    end
    chk("w_reach_9999", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bcd_w !== 16'h9999) found = 1'b1;
    end
    chk("w_roll_seen", 32'(found), 32'd1);
    chk("w_roll_bcd", 32'(bcd_w), 32'h0);
    chk("w_roll_wrap", 32'(wrap_w), 32'd1);
    chk("w_roll_running", 32'(running_w), 32'd1);
    @(negedge clk);
    chk("w_wrap_drop", 32'(wrap_w), 32'd0);
    chk("w_still_running", 32'(running_w), 32'd1);
    repeat (10) @(negedge clk);
    chk("w_wrap_count", 32'(wraps_seen), 32'd1);
    chk("w_after_bcd", 32'(bcd_w), 32'(to_bcd(w_model)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Start/stop/clear controller for the 4-digit seven-segment stopwatch on the 50 MHz board. It sequences a 4-digit BCD seconds counter through IDLE/RUN/PAUSE from two push-buttons. It generates the 1-second tick from a prescaler and time-multiplexes the four digits onto the shared segment and digit-select lines. It replaces ad-hoc free-running counting with a button-driven, resettable scheduler of the display resource.

Parameters:
TICK_DIV, 50000000, clocks per count tick (>=2)
SCAN_DIV, 8192, clocks each digit slot is driven (>=1)

Ports:
clk_i  in  1  system clock, 50 MHz
rst_i  in  1  reset
start_stop_i  in  1  raw button level, active-high, asynchronous to clk_i
clear_i  in  1  raw button level, active-high, asynchronous to clk_i
running_o  out  1  high while the FSM is in RUN
bcd_o  out  16  count in BCD, [15:12] thousands ... [3:0] ones
wrap_o  out  1  one-cycle pulse on the 9999->0000 rollover
led_segment_o  out  7  segments abcdefg (a = bit 6), active-low
digit_o  out  4  digit enables, active-low

Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).

Behaviour:
- Reset values (asserted immediately on rst_i, including mid-operation): state=IDLE, running_o=0, bcd_o=16'h0000, wrap_o=0, digit_o=4'b1111, led_segment_o=7'h7F, prescaler=0, scan counter=0, and all sync/edge flops=0.
- Button path: 2-flop synchronizer followed by a rising-edge detector, giving one single-cycle event per press. The event is seen by the FSM 2 cycles after the first edge sampling the input high. A held level produces no further events.
- FSM:
  - IDLE + ss event -> RUN. The prescaler is cleared on this entry.
  - RUN + ss event -> PAUSE.
  - PAUSE + ss event -> RUN. The prescaler is not cleared, so the partial second is preserved.
  - PAUSE + clear event -> IDLE. bcd_o=0 and prescaler=0.
  - IDLE + clear event -> stay in IDLE. bcd_o is already 0.
  - RUN + clear event -> ignored.
  - Simultaneous ss and clear in PAUSE -> clear wins, go to IDLE.
  - Simultaneous ss and clear in RUN -> ss wins, go to PAUSE; the clear is dropped.
- running_o is registered and equals (state==RUN).
- Prescaler: width $clog2(TICK_DIV). It advances only in RUN and holds in PAUSE. On reaching TICK_DIV-1 it returns to 0 and issues a tick that same cycle.
- Tick timing: with RUN entered at edge E, the first tick occurs when prescaler==TICK_DIV-1, and bcd_o updates at edge E+TICK_DIV.
- BCD increment:
  - Ones digit 9 -> 0 carries into tens, tens carries into hundreds, hundreds into thousands.
  - 9999 -> 0000 asserts wrap_o for exactly one cycle, aligned with bcd_o showing 0000. The FSM stays in RUN.
  - Every digit is always 0-9.
- Scan:
  - A free-running counter runs modulo 4*SCAN_DIV in all states; slot = counter/SCAN_DIV.
  - Slot 0 -> ones, digit_o=4'b0111.
  - Slot 1 -> tens, 4'b1011.
  - Slot 2 -> hundreds, 4'b1101.
  - Slot 3 -> thousands, 4'b1110.
  - digit_o and led_segment_o are registered and update 1 cycle after the slot or value changes. They always switch together, so there are no mixed-digit frames.
- Segment table (before inversion): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B. led_segment_o is the bitwise inverse.
- No leading-zero blanking; all four digits are always driven in turn.

Decomposition:
- Package stopwatch_pkg:
  - state_t enum (IDLE, RUN, PAUSE)
  - SEG7_LUT constant array [10] of 7-bit codes
  - DIGIT_SEL constants [4] (0111, 1011, 1101, 1110)
  - function bcd_inc returning {carry, next digit}
- Sub-module btn_sync_edge (2-flop synchronizer + rising-edge pulse), instantiated once per button.

Test Plan (TICK_DIV=4, SCAN_DIV=2 unless noted):
1. Reset: hold rst_i, then release -> running_o=0, bcd_o=0000, digit_o=1111 and led_segment_o=7F until the first registered scan update. Next, digit_o=0111 with led_segment_o=0x01 (digit "0").
2. Start: one-cycle ss press -> running_o=1 after 2-3 cycles; bcd_o goes 0001, 0002, 0003 on every 4th clock after RUN entry.
3. Pause/resume: pause when prescaler=2, wait 50 cycles -> bcd_o is frozen. Resume -> next increment 2 cycles after re-entering RUN.
4. Carry/wrap (TICK_DIV=2): run 10000 ticks -> 0009->0010, 0099->0100, 0999->1000, 9999->0000 with wrap_o high for exactly 1 cycle; running_o stays 1.
5. Clear:
   - clear in RUN -> no change.
   - clear in PAUSE -> IDLE, bcd_o=0000.
   - ss and clear in the same cycle from PAUSE -> IDLE.
   - ss and clear in the same cycle from RUN -> PAUSE with count kept.
   - rst_i asserted mid-RUN -> all outputs return to reset values immediately.
6. Scan with bcd_o=1234 -> repeating 2-cycle slots:
   - digit_o=0111, led_segment_o=0x4C
   - digit_o=1011, led_segment_o=0x06
   - digit_o=1101, led_segment_o=0x12
   - digit_o=1110, led_segment_o=0x4F
